// File: rtl/nic_pkg.sv
// Shared constants for the network interface controller: data width, the
// virtual-channel bit used for polarity gating, and the processor register map.
package nic_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned VC_BIT     = 63;

  // Processor-side register map.
  localparam logic [1:0] NIC_IN_BUF     = 2'b00;
  localparam logic [1:0] NIC_IN_STATUS  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF    = 2'b10;
  localparam logic [1:0] NIC_OUT_STATUS = 2'b11;

endpackage : nic_pkg

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with a full/empty status bit.
// load_i captures data_i and marks the entry full; clr_i marks it empty.
// The data register is left untouched by clr_i so stale contents stay readable.
module nic_channel_buffer
  import nic_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             status_o
);

  logic [Width-1:0] data_q, data_d;
  logic             status_q, status_d;

  // Next-state: load wins over clear; callers never assert both together since
  // load requires an empty entry and clear requires a full one.
  always_comb begin
    data_d   = data_q;
    status_d = status_q;
    if (load_i) begin
      data_d   = data_i;
      status_d = 1'b1;
    end else if (clr_i) begin
      status_d = 1'b0;
    end
  end

  // Entry and status registers; reset empties the buffer and discards its data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      status_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign data_o   = data_q;
  assign status_o = status_q;

endmodule : nic_channel_buffer

// File: rtl/nic.sv
// Network interface controller: bridges the processor NIC port to one router
// port. An input and an output one-entry channel buffer are exposed to the
// processor through a 2-bit register map; the router side uses a send/ready
// handshake and the output only transmits when the packet's VC bit matches
// the router's current polarity.
module nic #(
  parameter int unsigned DATA_WIDTH = nic_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = nic_pkg::ADDR_WIDTH,
  parameter int unsigned VC_BIT     = nic_pkg::VC_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  import nic_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] AddrInBuf     = ADDR_WIDTH'(NIC_IN_BUF);
  localparam logic [ADDR_WIDTH-1:0] AddrInStatus  = ADDR_WIDTH'(NIC_IN_STATUS);
  localparam logic [ADDR_WIDTH-1:0] AddrOutBuf    = ADDR_WIDTH'(NIC_OUT_BUF);
  localparam logic [ADDR_WIDTH-1:0] AddrOutStatus = ADDR_WIDTH'(NIC_OUT_STATUS);

  logic                  rd_en, wr_en;
  logic                  in_load, in_clr, in_status;
  logic [DATA_WIDTH-1:0] in_buf;
  logic                  out_load, out_status;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  tx_fire;

  logic                  net_so_q, net_so_d;
  logic [DATA_WIDTH-1:0] net_do_q, net_do_d;

  assign rd_en = nicEn & ~nicEnWr;
  assign wr_en = nicEn & nicEnWr;

  // Inbound: accept only into an empty buffer; a send into a full buffer is dropped.
  assign in_load = net_si & ~in_status;
  // Reading the input buffer consumes the packet, but only if one is present.
  assign in_clr  = rd_en & (addr == AddrInBuf) & in_status;

  // Outbound: a write into a full output buffer is silently dropped.
  assign out_load = wr_en & (addr == AddrOutBuf) & ~out_status;
  // Transmit only when the packet's VC bit matches the router's current phase.
  assign tx_fire  = out_status & net_ro & (out_buf[VC_BIT] == net_polarity);

  nic_channel_buffer #(
    .Width (DATA_WIDTH)
  ) u_in_chan (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (in_load),
    .clr_i    (in_clr),
    .data_i   (net_di),
    .data_o   (in_buf),
    .status_o (in_status)
  );

  nic_channel_buffer #(
    .Width (DATA_WIDTH)
  ) u_out_chan (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (out_load),
    .clr_i    (tx_fire),
    .data_i   (d_in),
    .data_o   (out_buf),
    .status_o (out_status)
  );

  // Router-side outputs: net_so is a single-cycle pulse, net_do holds the last packet.
  always_comb begin
    net_so_d = tx_fire;
    net_do_d = net_do_q;
    if (tx_fire) begin
      net_do_d = out_buf;
    end
  end

  // Registered router-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      net_so_q <= 1'b0;
      net_do_q <= '0;
    end else begin
      net_so_q <= net_so_d;
      net_do_q <= net_do_d;
    end
  end

  // Processor read mux; returns zero whenever no read is in progress.
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      unique case (addr)
        AddrInBuf:     d_out = in_buf;
        AddrInStatus:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_status};
        AddrOutStatus: d_out = {{(DATA_WIDTH-1){1'b0}}, out_status};
        default:       d_out = '0;
      endcase
    end
  end

  assign net_ri = ~in_status;
  assign net_so = net_so_q;
  assign net_do = net_do_q;

endmodule : nic

// File: tb/tb_nic.sv
// Randomised scoreboard bench for nic. The driver updates a transaction-level
// model of both channels and queues the expected responses; a monitor on the
// falling edge pops and compares whenever the DUT presents a read or a packet.
module tb_nic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicEnWr = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;

  nic #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (2),
    .VC_BIT     (63)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [63:0] data;
  } tx_t;

  // Transaction-level model state: each channel is just "full?" plus a packet.
  bit          m_in_full  = 1'b0;
  bit          m_out_full = 1'b0;
  logic [63:0] m_in_data  = '0;
  logic [63:0] m_out_data = '0;
  logic [63:0] last_do    = '0;

  logic [63:0] rd_q[$];
  bit          ri_q[$];
  tx_t         tx_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event absent or unexpected (cycle %0d)", name, cyc);
  endtask

  // One processor/router cycle; inputs change 1ns after the rising edge.
  task automatic step(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] din,
                      input bit si, input logic [63:0] di, input bit ro);
    logic [63:0] exp_rd;
    bit          fire;
    tx_t         t;
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
    nicEn   = en;
    nicEnWr = wr;
    addr    = a;
    d_in    = din;
    net_si  = si;
    net_di  = di;
    net_ro  = ro;

    ri_q.push_back(!m_in_full);
    if (en && !wr) begin
      case (a)
        2'b00:   exp_rd = m_in_data;
        2'b01:   exp_rd = 64'(m_in_full);
        2'b11:   exp_rd = 64'(m_out_full);
        default: exp_rd = '0;
      endcase
      rd_q.push_back(exp_rd);
    end

    fire = m_out_full && ro && (m_out_data[63] == net_polarity);
    if (fire) begin
      t.at   = cyc + 1;
      t.data = m_out_data;
      tx_q.push_back(t);
    end

    // Inbound: a read of the buffer pops a present packet; a send lands only if empty.
    if (si && !m_in_full) begin
      m_in_full = 1'b1;
      m_in_data = di;
    end else if (en && !wr && a == 2'b00 && m_in_full) begin
      m_in_full = 1'b0;
    end

    // Outbound: a transmit empties the buffer; a write fills it only if it was empty.
    if (fire) begin
      m_out_full = 1'b0;
    end else if (en && wr && a == 2'b10 && !m_out_full) begin
      m_out_full = 1'b1;
      m_out_data = din;
    end
  endtask

  task automatic idle(input bit ro);
    step(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, ro);
  endtask

  task automatic rd(input logic [1:0] a, input bit ro);
    step(1'b1, 1'b0, a, '0, 1'b0, '0, ro);
  endtask

  // Reset mid-operation: drop everything in flight and check the reset-time outputs.
  task automatic reset_dut();
    @(posedge clk);
    #1;
    nicEn  = 1'b0;
    net_si = 1'b0;
    net_ro = 1'b0;
    rst    = 1'b0;
    rd_q.delete();
    ri_q.delete();
    tx_q.delete();
    m_in_full  = 1'b0;
    m_out_full = 1'b0;
    m_in_data  = '0;
    m_out_data = '0;
    last_do    = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compares whatever the DUT is presenting against the queued expectations.
  always @(negedge clk) begin
    tx_t t;
    if (!rst) begin
      chk("reset d_out", d_out, '0);
      chk("reset net_so", 64'(net_so), '0);
      chk("reset net_do", net_do, '0);
      chk("reset net_ri", 64'(net_ri), 64'd1);
    end else begin
      if (ri_q.size() != 0) chk("net_ri", 64'(net_ri), 64'(ri_q.pop_front()));
      if (nicEn && !nicEnWr) begin
        if (rd_q.size() == 0) miss("read without expectation");
        else chk("d_out read", d_out, rd_q.pop_front());
      end else begin
        chk("d_out idle", d_out, '0);
      end
      while (tx_q.size() != 0 && tx_q[0].at < cyc) begin
        miss("net_so pulse missing");
        void'(tx_q.pop_front());
      end
      if (net_so) begin
        if (tx_q.size() != 0 && tx_q[0].at == cyc) begin
          t = tx_q.pop_front();
          chk("net_do packet", net_do, t.data);
          last_do = t.data;
        end else begin
          miss("net_so unexpected");
        end
      end else begin
        if (tx_q.size() != 0 && tx_q[0].at == cyc) begin
          miss("net_so pulse missing");
          void'(tx_q.pop_front());
        end
        chk("net_do hold", net_do, last_do);
      end
    end
  end

  initial begin
    logic [63:0] pkt;
    // Power-on reset; monitor checks outputs while rst is low.
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    rd(2'b01, 1'b0);
    rd(2'b11, 1'b0);

    // Inbound capture, status, consume, status clears.
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);

    // Outbound with polarity gating.
    step(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00AA, 1'b0, '0, 1'b1);
    repeat (4) idle(1'b1);
    rd(2'b11, 1'b1);

    // Backpressure: packet held, second write dropped, original sent later.
    step(1'b1, 1'b1, 2'b10, 64'h0000_0000_0000_0077, 1'b0, '0, 1'b0);
    repeat (5) rd(2'b11, 1'b0);
    step(1'b1, 1'b1, 2'b10, 64'h5, 1'b0, '0, 1'b0);
    repeat (4) idle(1'b1);
    rd(2'b11, 1'b1);

    // Overrun: second send into a full input buffer is dropped.
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'hAAAA_5555_0000_0042, 1'b0);
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h1234, 1'b0);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);
    rd(2'b01, 1'b0);

    // Concurrency: capture and transmit on the same edge.
    step(1'b1, 1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, '0, 1'b0);
    pkt = 64'h0123_4567_89AB_CDEF;
    pkt[63] = ~net_polarity;
    step(1'b1, 1'b1, 2'b10, pkt, 1'b0, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    pkt = {net_polarity, 63'h0F0F_0F0F_0F0F_0F0F};
    step(1'b1, 1'b1, 2'b10, pkt, 1'b0, '0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, 64'hCAFE_F00D_0000_0003, 1'b1);
    rd(2'b00, 1'b0);
    rd(2'b11, 1'b0);

    // Mid-operation reset with both channels loaded.
    step(1'b1, 1'b1, 2'b10, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'h7777, 1'b0);
    reset_dut();
    rd(2'b01, 1'b0);
    rd(2'b11, 1'b0);
    rd(2'b00, 1'b0);

    // Randomised traffic on both channels.
    for (int i = 0; i < 3000; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0));
    end
    repeat (4) idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("tx queue drained", 64'(tx_q.size()), '0);
    chk("read queue drained", 64'(rd_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nic

// File: doc/nic.md
Name: nic

Overview:
- Network interface controller: the far end of the processor's NIC port (nicEn/nicEnWr/address/data).
- Bridges the processor to one router port.
- Holds one-entry input and output channel buffers, each with a status bit.
- The processor accesses buffers and status through a 2-bit address map; the router side uses a send/ready handshake with polarity-gated transmission.

Parameters:
- DATA_WIDTH, 64, packet and processor data width.
- ADDR_WIDTH, 2, processor-side NIC register address width.
- VC_BIT, 63, packet bit compared against net_polarity before transmit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  processor register select.
- d_in  input  DATA_WIDTH  processor write data.
- d_out  output  DATA_WIDTH  processor read data.
- nicEn  input  1  processor access enable.
- nicEnWr  input  1  1 = write, 0 = read; qualified by nicEn.
- net_si  input  1  router sends packet into NIC this cycle.
- net_ri  output  1  NIC input buffer can accept a packet.
- net_di  input  DATA_WIDTH  packet from router.
- net_so  output  1  NIC sends packet to router this cycle.
- net_ro  input  1  router can accept a packet.
- net_do  output  DATA_WIDTH  packet to router.
- net_polarity  input  1  router phase; toggles every cycle.

Behaviour:
- Address map:
  - 00 = input buffer (read).
  - 01 = input status (read).
  - 10 = output buffer (write).
  - 11 = output status (read).
- Reset (rst=0, async):
  - Both buffers, in_status, out_status, net_so and net_do clear to 0.
  - net_ri=1 (it is the inverse of in_status).
  - d_out=0 whenever no read is active.
  - Reset mid-transfer discards buffered packets.
- Processor read (nicEn=1, nicEnWr=0), d_out combinational, same cycle:
  - 00 returns in_buf.
  - 01 returns {63'b0, in_status}.
  - 11 returns {63'b0, out_status}.
  - 10 returns 0.
- Reading 00 with in_status=1 clears in_status at the next edge.
- Reading 00 with in_status=0 returns stale in_buf and leaves status unchanged.
- Processor write (nicEn=1, nicEnWr=1):
  - addr 10 with out_status=0 loads out_buf<=d_in and sets out_status<=1 at the edge.
  - addr 10 with out_status=1: write dropped, buffer unchanged. Software must poll 11 first.
  - Writes to 00/01/11 are ignored.
- nicEn=0: no state change; d_out=0.
- Input channel:
  - net_ri = ~in_status (combinational).
  - net_si=1 and in_status=0: in_buf<=net_di, in_status<=1 at the edge.
  - net_si=1 while in_status=1 is a protocol violation: packet dropped, buffer and status unchanged.
- Output channel: a transmit fires when out_status=1, net_ro=1 and out_buf[VC_BIT]==net_polarity. At that edge:
  - net_so<=1 and net_do<=out_buf (registered outputs).
  - out_status<=0.
- net_so is a one-cycle pulse; it is 0 in every other cycle.
- net_do holds its last value after the pulse.
- Latency:
  - Write to net_so: earliest 2 edges (load, then transmit edge); the pulse is visible after the second edge.
  - net_di to readable: 1 edge.
- Simultaneous events:
  - Input-buffer read-clear and net_si at the same edge cannot occur (net_ri=0 while full); net_ri rises the cycle after the clear.
  - Processor write to 10 in the same cycle as a transmit edge sees out_status=1 and is dropped. The new packet is accepted only from the next cycle.
  - Input and output channels operate independently and concurrently.

Decomposition:
- Shared package holds:
  - Address constants NIC_IN_BUF=2'b00, NIC_IN_STATUS=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STATUS=2'b11.
  - VC_BIT.
  - DATA_WIDTH.
- Natural sub-module: nic_channel_buffer, a one-entry buffer plus status bit with load/clear strobes.
- nic instantiates nic_channel_buffer twice (input and output); address decode, polarity gating and net_so/net_do registers live in the top.

Test Plan:
- Reset: assert rst=0 mid-operation → d_out=0, net_so=0, net_do=0, net_ri=1, reads of 01 and 11 return 0 after release.
- Inbound: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 → net_ri=0 next cycle; read 01 returns 1; read 00 returns the packet; next cycle 01 returns 0 and net_ri=1.
- Outbound polarity:
  - Stimulus: write 10 with d_in=64'h8000_0000_0000_00AA, net_ro=1, polarity toggling.
  - Response: net_so pulses once, only on an edge where net_polarity=1; net_do=64'h8000_0000_0000_00AA; then 11 reads 0.
- Backpressure: net_ro=0 for 5 cycles with out_status=1 → no net_so, 11 reads 1; a second write to 10 (d_in=64'h5) is dropped; after net_ro=1, the original packet is sent.
- Overrun: in_status=1, drive net_si=1 with net_di=64'h1234 → in_buf keeps the prior value, status stays 1.
- Concurrency: inbound capture and outbound transmit on the same edge → both complete correctly; no cross-channel corruption.
